step_motor_sequencer: RTL and testbench

Drives one bipolar stepper through a four-wire coil interface: AX/AY for coil A and BX/BY for coil B. These are the same signals the motor ports consume for each step_motor_driver channel. The block accepts move commands (step count, direction, rate, full/half step), sequences the 8-entry coil phase table at a programmable rate, and tracks absolute position. One instance is used per motor channel, behind the qsys register interface.

---
 rtl/step_motor_pkg.sv | 36 +++
 rtl/step_rate_timer.sv | 49 ++++
 rtl/step_motor_sequencer.sv | 154 +++++++++++++++
 tb/tb_step_motor_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/step_motor_pkg.sv
// -----------------------------------------------------------------------------
// step_motor_pkg
// Shared definitions for the stepper sequencer:
//   - state_t      : sequencer FSM state encoding (IDLE, RUN)
//   - PHASE_TABLE  : 8-entry coil pattern table, entry = {AX,AY,BX,BY}
//   - PERIOD_MIN   : smallest legal step period in clk cycles
//   - phase_coils  : table lookup helper
// No ports (package).
// -----------------------------------------------------------------------------
package step_motor_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int PERIOD_MIN = 2;

    // Element [0] is the least significant nibble, so the literal reads from
    // index 7 down to index 0.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b0010,  // 7
        4'b0110,  // 6
        4'b0100,  // 5
        4'b0101,  // 4
        4'b0001,  // 3
        4'b1001,  // 2
        4'b1000,  // 1
        4'b1010   // 0
    };

    function automatic logic [3:0] phase_coils(input logic [2:0] idx);
        return PHASE_TABLE[idx];
    endfunction

endpackage

// File: rtl/step_rate_timer.sv
// -----------------------------------------------------------------------------
// step_rate_timer
// Loadable down-counter that sets the step rate. While enabled it counts down
// to zero, raises tick for the cycle in which the count is zero, and reloads
// the last loaded value on that same edge, giving one tick every
// (load_value + 1) cycles. While disabled the count holds.
// Ports:
//   clk        in   system clock
//   reset_n    in   synchronous active-low reset
//   load       in   capture load_value as both count and reload value
//   load_value in   CNT_WIDTH reload value (period - 1)
//   enable     in   count down / reload when high
//   tick       out  high while enabled and count is zero
// -----------------------------------------------------------------------------
module step_rate_timer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic                 enable,
    output logic                 tick
);

    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] reload;

    // A load wins over a tick in the same cycle so a fresh move never starts
    // with a stale step.
    assign tick = enable && !load && (count == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count  <= '0;
            reload <= '0;
        end else if (load) begin
            count  <= load_value;
            reload <= load_value;
        end else if (enable) begin
            if (count == '0) begin
                count <= reload;
            end else begin
                count <= count - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/step_motor_sequencer.sv
// -----------------------------------------------------------------------------
// step_motor_sequencer
// Drives one bipolar stepper (coil A = AX/AY, coil B = BX/BY) by walking an
// 8-entry phase table at a programmable rate, and tracks absolute position in
// half-step units.
//
// Control handshake: start and stop are single-cycle requests with no ready
// return. start is taken only when the sequencer is idle (busy low) and
// latches dir, half_step, period (clamped to at least 2) and steps on that
// edge; a start while busy is dropped. stop is honoured only while busy and
// ends the move on the next edge. Every move ends with exactly one done pulse;
// reset ends a move silently.
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   start, stop               move request / abort
//   dir, half_step            direction (1 = forward), 1 = half-step
//   hold_en                   keep the current phase energised while idle
//   period                    clk cycles per step
//   steps                     step count, 0 = run until stop
//   AX, AY, BX, BY            registered coil drive
//   busy                      high while a move runs
//   done                      one-cycle end-of-move pulse
//   position                  signed absolute position (half-steps)
//   steps_left                remaining steps (0 in continuous mode)
//   state_dbg                 current FSM state
// -----------------------------------------------------------------------------
module step_motor_sequencer
    import step_motor_pkg::*;
#(
    parameter int CNT_WIDTH  = 16,
    parameter int STEP_WIDTH = 16,
    parameter int POS_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        dir,
    input  logic                        half_step,
    input  logic                        hold_en,
    input  logic [CNT_WIDTH-1:0]        period,
    input  logic [STEP_WIDTH-1:0]       steps,
    output logic                        AX,
    output logic                        AY,
    output logic                        BX,
    output logic                        BY,
    output logic                        busy,
    output logic                        done,
    output logic signed [POS_WIDTH-1:0] position,
    output logic [STEP_WIDTH-1:0]       steps_left,
    output state_t                      state_dbg
);

    state_t                state;
    logic [2:0]            index;
    logic                  dir_r;
    logic                  half_r;
    logic                  cont_r;
    logic [3:0]            coil_q;

    logic [CNT_WIDTH-1:0]  period_c;
    logic [CNT_WIDTH-1:0]  load_value;
    logic                  timer_load;
    logic                  timer_en;
    logic                  tick;

    logic [2:0]            idx_step;
    logic [2:0]            next_index;
    logic [POS_WIDTH-1:0]  pos_step;
    logic [POS_WIDTH-1:0]  next_position;
    logic                  last_step;

    // Periods of 0 or 1 cannot be represented as a reload of period-1 with a
    // visible gap between steps, so they are raised to PERIOD_MIN.
    assign period_c   = (period < CNT_WIDTH'(PERIOD_MIN)) ? CNT_WIDTH'(PERIOD_MIN) : period;
    assign load_value = period_c - CNT_WIDTH'(1);
    assign timer_load = (state == IDLE) && start;
    assign timer_en   = (state == RUN);

    step_rate_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (load_value),
        .enable     (timer_en),
        .tick       (tick)
    );

    // Full-step moves two table entries, so parity of the index is kept: an
    // odd index stays in single-coil (wave) drive on purpose.
    assign idx_step      = half_r ? 3'd1 : 3'd2;
    assign next_index    = dir_r ? (index + idx_step) : (index - idx_step);
    assign pos_step      = half_r ? POS_WIDTH'(1) : POS_WIDTH'(2);
    assign next_position = dir_r ? (position + pos_step) : (position - pos_step);
    assign last_step     = tick && !cont_r && (steps_left == STEP_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            index      <= 3'd0;
            dir_r      <= 1'b0;
            half_r     <= 1'b0;
            cont_r     <= 1'b0;
            coil_q     <= 4'b0000;
            done       <= 1'b0;
            position   <= '0;
            steps_left <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        dir_r      <= dir;
                        half_r     <= half_step;
                        cont_r     <= (steps == '0);
                        steps_left <= steps;
                        coil_q     <= phase_coils(index);
                    end else begin
                        coil_q <= hold_en ? phase_coils(index) : 4'b0000;
                    end
                end
                RUN: begin
                    if (tick) begin
                        index    <= next_index;
                        position <= next_position;
                        if (!cont_r) begin
                            steps_left <= steps_left - STEP_WIDTH'(1);
                        end
                    end
                    // Coils follow the index on the same edge it changes.
                    coil_q <= phase_coils(tick ? next_index : index);
                    // A stop that coincides with a tick still lets that step
                    // complete; the tick branch above has already taken it.
                    if (stop || last_step) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign {AX, AY, BX, BY} = coil_q;
    assign busy             = (state == RUN);
    assign state_dbg        = state;

endmodule

// File: tb/tb_step_motor_sequencer.sv
module tb_step_motor_sequencer;
    import step_motor_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, dir = 1'b0, half_step = 1'b0, hold_en = 1'b0;
    logic [15:0] period = '0, steps = '0;
    logic        AX, AY, BX, BY, busy, done;
    logic signed [31:0] position;
    logic [15:0] steps_left;
    state_t      state_dbg;

    // narrow-position instance used for the wrap boundary
    logic        w_start = 1'b0;
    logic        w_AX, w_AY, w_BX, w_BY, w_busy, w_done;
    logic signed [3:0] w_position;
    logic [15:0] w_steps_left;
    state_t      w_state_dbg;

    step_motor_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .dir(dir),
        .half_step(half_step), .hold_en(hold_en), .period(period), .steps(steps),
        .AX(AX), .AY(AY), .BX(BX), .BY(BY), .busy(busy), .done(done),
        .position(position), .steps_left(steps_left), .state_dbg(state_dbg)
    );

    step_motor_sequencer #(.POS_WIDTH(4)) dut_w (
        .clk(clk), .reset_n(reset_n), .start(w_start), .stop(stop), .dir(dir),
        .half_step(half_step), .hold_en(hold_en), .period(period), .steps(steps),
        .AX(w_AX), .AY(w_AY), .BX(w_BX), .BY(w_BY), .busy(w_busy), .done(w_done),
        .position(w_position), .steps_left(w_steps_left), .state_dbg(w_state_dbg)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [3:0] exp_q[$];
    logic [3:0] prev_c;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] coils();
        return {AX, AY, BX, BY};
    endfunction

    task automatic expect_coils(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_q_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, {28'd0, coils()}, {28'd0, e});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
    endtask

    // Returns half a cycle after the edge that accepts the start.
    task automatic pulse_start(input logic [15:0] p, input logic [15:0] s,
                               input logic d, input logic h);
        period = p; steps = s; dir = d; half_step = h;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        cyc(1);

        // T1: reset state, coast, then hold
        hold_en = 1'b0;
        do_reset();
        check_eq("rst_coils", {28'd0, coils()}, 32'h0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_pos", position, 32'd0);
        check_eq("rst_sl", {16'd0, steps_left}, 32'd0);
        cyc(1);
        check_eq("coast_coils", {28'd0, coils()}, 32'h0);
        hold_en = 1'b1;
        cyc(1);
        check_eq("hold_coils", {28'd0, coils()}, 32'hA);

        // T2: 4 full steps forward, period 3; inputs changed mid-move
        do_reset();
        cyc(1);
        pulse_start(16'd3, 16'd4, 1'b1, 1'b0);
        check_eq("t2_busy", {31'd0, busy}, 32'd1);
        check_eq("t2_state", {31'd0, state_dbg}, {31'd0, RUN});
        check_eq("t2_coils0", {28'd0, coils()}, 32'hA);
        check_eq("t2_sl0", {16'd0, steps_left}, 32'd4);
        dir = 1'b0; period = 16'd7; steps = 16'd1; half_step = 1'b1;
        exp_q.push_back(4'b1001);
        exp_q.push_back(4'b0101);
        exp_q.push_back(4'b0110);
        exp_q.push_back(4'b1010);
        prev_c = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            cyc(2);
            check_eq("t2_no_early", {28'd0, coils()}, {28'd0, prev_c});
            cyc(1);
            prev_c = exp_q[0];
            expect_coils("t2_step");
        end
        check_eq("t2_done", {31'd0, done}, 32'd1);
        check_eq("t2_busy_end", {31'd0, busy}, 32'd0);
        check_eq("t2_pos", position, 32'd8);
        check_eq("t2_sl_end", {16'd0, steps_left}, 32'd0);
        cyc(1);
        check_eq("t2_done_clr", {31'd0, done}, 32'd0);
        check_eq("t2_hold", {28'd0, coils()}, 32'hA);

        // T3: 3 half steps reverse from index 0
        do_reset();
        pulse_start(16'd2, 16'd3, 1'b0, 1'b1);
        check_eq("t3_sl0", {16'd0, steps_left}, 32'd3);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0110);
        exp_q.push_back(4'b0100);
        for (int k = 0; k < 3; k++) begin
            cyc(2);
            expect_coils("t3_step");
            check_eq("t3_sl", {16'd0, steps_left}, 32'(2 - k));
        end
        check_eq("t3_pos", position, 32'hFFFF_FFFD);
        check_eq("t3_done", {31'd0, done}, 32'd1);

        // T4a: continuous, period 5, stop between ticks
        do_reset();
        pulse_start(16'd5, 16'd0, 1'b1, 1'b0);
        check_eq("t4_sl0", {16'd0, steps_left}, 32'd0);
        cyc(5);
        check_eq("t4_c5", {28'd0, coils()}, 32'h9);
        check_eq("t4_p5", position, 32'd2);
        cyc(5);
        check_eq("t4_c10", {28'd0, coils()}, 32'h5);
        cyc(2);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check_eq("t4_done", {31'd0, done}, 32'd1);
        check_eq("t4_busy", {31'd0, busy}, 32'd0);
        check_eq("t4_pos", position, 32'd4);
        check_eq("t4_coils", {28'd0, coils()}, 32'h5);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check_eq("t4_idle_stop", {31'd0, done}, 32'd0);

        // T4b: stop coincides with third tick
        pulse_start(16'd5, 16'd0, 1'b1, 1'b0);
        cyc(5);
        check_eq("t4b_c5", {28'd0, coils()}, 32'h6);
        cyc(5);
        check_eq("t4b_c10", {28'd0, coils()}, 32'hA);
        cyc(4);
        check_eq("t4b_p14", position, 32'd8);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check_eq("t4b_pos", position, 32'd10);
        check_eq("t4b_coils", {28'd0, coils()}, 32'h9);
        check_eq("t4b_done", {31'd0, done}, 32'd1);
        check_eq("t4b_busy", {31'd0, busy}, 32'd0);

        // T5: period 0 clamps to 2, start while busy ignored; then period 1
        do_reset();
        pulse_start(16'd0, 16'd3, 1'b1, 1'b1);
        check_eq("t5_p1", position, 32'd0);
        cyc(1);
        check_eq("t5_p1b", position, 32'd0);
        start = 1'b1; steps = 16'd9;
        cyc(1);
        start = 1'b0;
        check_eq("t5_p2", position, 32'd1);
        check_eq("t5_sl2", {16'd0, steps_left}, 32'd2);
        cyc(2);
        check_eq("t5_p4", position, 32'd2);
        check_eq("t5_sl4", {16'd0, steps_left}, 32'd1);
        cyc(2);
        check_eq("t5_p6", position, 32'd3);
        check_eq("t5_done", {31'd0, done}, 32'd1);
        pulse_start(16'd1, 16'd1, 1'b1, 1'b1);
        check_eq("t5b_busy", {31'd0, busy}, 32'd1);
        cyc(1);
        check_eq("t5b_p1", position, 32'd3);
        cyc(1);
        check_eq("t5b_p2", position, 32'd4);
        check_eq("t5b_done", {31'd0, done}, 32'd1);

        // T6: reset mid-move
        do_reset();
        pulse_start(16'd2, 16'd0, 1'b1, 1'b1);
        cyc(2);
        check_eq("t6_pos_pre", position, 32'd1);
        reset_n = 1'b0;
        cyc(1);
        check_eq("t6_busy", {31'd0, busy}, 32'd0);
        check_eq("t6_done", {31'd0, done}, 32'd0);
        check_eq("t6_pos", position, 32'd0);
        check_eq("t6_coils", {28'd0, coils()}, 32'h0);
        reset_n = 1'b1;
        cyc(1);
        check_eq("t6_done_after", {31'd0, done}, 32'd0);
        check_eq("t6_hold", {28'd0, coils()}, 32'hA);

        // T7: signed position wrap on the 4-bit instance
        do_reset();
        period = 16'd2; steps = 16'd7; dir = 1'b1; half_step = 1'b1;
        w_start = 1'b1;
        cyc(1);
        w_start = 1'b0;
        cyc(14);
        check_eq("t7_pos_max", {28'd0, w_position}, 32'h7);
        check_eq("t7_done", {31'd0, w_done}, 32'd1);
        check_eq("t7_main_idle", {31'd0, busy}, 32'd0);
        steps = 16'd1;
        w_start = 1'b1;
        cyc(1);
        w_start = 1'b0;
        cyc(2);
        check_eq("t7_pos_wrap", {28'd0, w_position}, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
